// File: rtl/rs_age_queue_pkg.sv
// Shared types and constants for the age-ordered reservation station.
// Operand, label and opcode widths are fixed here so that the entry record
// and every user of it agree on one layout.
package rs_age_queue_pkg;

    localparam int TAG_W = 4;
    localparam int VAL_W = 32;
    localparam int OP_W  = 7;

    // Label value meaning "operand is final, no producer outstanding".
    localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b0}};

    // One waiting instruction.
    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] q1;
        logic [VAL_W-1:0] v1;
        logic [TAG_W-1:0] q2;
        logic [VAL_W-1:0] v2;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_queue_if.sv
// Dispatch, result-broadcast and issue bundle of the reservation station.
// master: the surrounding core (decoder/ROB, CDB, ALU); slave: the station.
interface rs_age_queue_if
    import rs_age_queue_pkg::*;
#(
    parameter int CDB_PORTS = 3
) ();

    logic                       disp_valid;
    logic                       disp_ready;
    logic [OP_W-1:0]            disp_op;
    logic [TAG_W-1:0]           disp_tag;
    logic [TAG_W-1:0]           disp_q1;
    logic [TAG_W-1:0]           disp_q2;
    logic [VAL_W-1:0]           disp_v1;
    logic [VAL_W-1:0]           disp_v2;

    logic [CDB_PORTS-1:0]       wb_valid;
    logic [CDB_PORTS*TAG_W-1:0] wb_tag;
    logic [CDB_PORTS*VAL_W-1:0] wb_val;

    logic                       ex_valid;
    logic                       ex_ready;
    logic [OP_W-1:0]            ex_op;
    logic [TAG_W-1:0]           ex_tag;
    logic [VAL_W-1:0]           ex_v1;
    logic [VAL_W-1:0]           ex_v2;

    modport master (
        output disp_valid, disp_op, disp_tag, disp_q1, disp_q2, disp_v1, disp_v2,
        output wb_valid, wb_tag, wb_val, ex_ready,
        input  disp_ready, ex_valid, ex_op, ex_tag, ex_v1, ex_v2
    );

    modport slave (
        input  disp_valid, disp_op, disp_tag, disp_q1, disp_q2, disp_v1, disp_v2,
        input  wb_valid, wb_tag, wb_val, ex_ready,
        output disp_ready, ex_valid, ex_op, ex_tag, ex_v1, ex_v2
    );

endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix for N slots. older_q[j][i] = 1 means slot j was allocated before
// slot i. The grant is the requesting slot that no other requester is older
// than. Bits involving free slots may be stale; they are overwritten when the
// slot is allocated again, and free slots never request.
module rs_age_matrix #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic [N-1:0] alloc_i,
    input  logic [N-1:0] free_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

    logic [N-1:0] valid_q;
    logic [N-1:0] valid_d;
    logic [N-1:0] older_q [N];
    logic [N-1:0] older_d [N];

    // Next-state: allocation makes the new slot younger than every live slot.
    always_comb begin
        valid_d = valid_q;
        for (int j = 0; j < N; j++) begin
            older_d[j] = older_q[j];
        end
        if (flush_i) begin
            valid_d = {N{1'b0}};
            for (int j = 0; j < N; j++) begin
                older_d[j] = {N{1'b0}};
            end
        end else begin
            valid_d = alloc_i | (valid_q & ~free_i);
            for (int j = 0; j < N; j++) begin
                for (int i = 0; i < N; i++) begin
                    older_d[j][i] = alloc_i[j] ? 1'b0
                                  : (alloc_i[i] ? valid_q[j] : older_q[j][i]);
                end
            end
        end
    end

    // Oldest-ready grant: a requester wins when no other requester is older.
    always_comb begin
        logic [N-1:0] col;
        col     = {N{1'b0}};
        grant_o = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                col[j] = older_q[j][i];
            end
            grant_o[i] = req_i[i] & ~(|(req_i & col));
        end
    end

    // Matrix and live-slot state register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q <= {N{1'b0}};
            for (int j = 0; j < N; j++) begin
                older_q[j] <= {N{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            for (int j = 0; j < N; j++) begin
                older_q[j] <= older_d[j];
            end
        end
    end

endmodule

// File: rtl/rs_age_queue.sv
// Reservation station with age-ordered issue to the ALU.
// Holds RS_DEPTH waiting instructions, snoops CDB_PORTS result broadcasts,
// and issues the oldest ready entry through a valid/ready issue register.
// Optional macro RS_WAKEUP_BYPASS_EN: readiness and issued operands use the
// post-wakeup operand state, so a broadcast can feed the issue in its own cycle.
module rs_age_queue
    import rs_age_queue_pkg::*;
#(
    parameter  int RS_DEPTH  = 8,
    parameter  int CDB_PORTS = 3,
    localparam int CNT_W     = $clog2(RS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    rs_age_queue_if.slave    io,
    output logic [CNT_W-1:0] free_cnt
);

    rs_entry_t ent_q [RS_DEPTH];
    rs_entry_t ent_d [RS_DEPTH];
    rs_entry_t ent_w [RS_DEPTH];
    rs_entry_t src_s [RS_DEPTH];
    rs_entry_t new_s;
    rs_entry_t sel_s;

    logic [RS_DEPTH-1:0] busy_s;
    logic [RS_DEPTH-1:0] ready_s;
    logic [RS_DEPTH-1:0] grant_s;
    logic [RS_DEPTH-1:0] free_oh_s;
    logic [RS_DEPTH-1:0] alloc_s;
    logic [RS_DEPTH-1:0] issue_s;
    logic [CNT_W-1:0]    cnt_s;
    logic                fire_s;
    logic                load_s;

    logic                ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]     ex_op_q,    ex_op_d;
    logic [TAG_W-1:0]    ex_tag_q,   ex_tag_d;
    logic [VAL_W-1:0]    ex_v1_q,    ex_v1_d;
    logic [VAL_W-1:0]    ex_v2_q,    ex_v2_d;

    // Operand snoop: the lowest-index valid port carrying the awaited label
    // supplies the value. A final operand (TAG_NONE) is never touched, which
    // also means label-0 broadcasts can never match.
    function automatic logic [TAG_W+VAL_W-1:0] snoop(
        input logic [TAG_W-1:0]           q,
        input logic [VAL_W-1:0]           v,
        input logic [CDB_PORTS-1:0]       wv,
        input logic [CDB_PORTS*TAG_W-1:0] wt,
        input logic [CDB_PORTS*VAL_W-1:0] wd
    );
        logic [TAG_W-1:0] qn;
        logic [VAL_W-1:0] vn;
        logic             hit;
        qn = q;
        vn = v;
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            hit = (q != TAG_NONE) && wv[p] && (wt[p*TAG_W +: TAG_W] == q);
            qn  = hit ? TAG_NONE : qn;
            vn  = hit ? wd[p*VAL_W +: VAL_W] : vn;
        end
        return {qn, vn};
    endfunction

    // Wakeup of stored operands plus race capture on the incoming entry.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_w[i] = ent_q[i];
            {ent_w[i].q1, ent_w[i].v1} = snoop(ent_q[i].q1, ent_q[i].v1,
                                               io.wb_valid, io.wb_tag, io.wb_val);
            {ent_w[i].q2, ent_w[i].v2} = snoop(ent_q[i].q2, ent_q[i].v2,
                                               io.wb_valid, io.wb_tag, io.wb_val);
        end
        new_s      = '0;
        new_s.busy = 1'b1;
        new_s.op   = io.disp_op;
        new_s.tag  = io.disp_tag;
        {new_s.q1, new_s.v1} = snoop(io.disp_q1, io.disp_v1,
                                     io.wb_valid, io.wb_tag, io.wb_val);
        {new_s.q2, new_s.v2} = snoop(io.disp_q2, io.disp_v2,
                                     io.wb_valid, io.wb_tag, io.wb_val);
    end

    // Readiness source: registered operands, or post-wakeup ones when bypassing.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            src_s[i] = ent_w[i];
`else
            src_s[i] = ent_q[i];
`endif
            busy_s[i]  = ent_q[i].busy;
            ready_s[i] = src_s[i].busy && (src_s[i].q1 == TAG_NONE)
                                       && (src_s[i].q2 == TAG_NONE);
        end
    end

    // Free-slot search (lowest index) and free-entry count from registered busy bits.
    always_comb begin
        logic found;
        found     = 1'b0;
        free_oh_s = {RS_DEPTH{1'b0}};
        cnt_s     = {CNT_W{1'b0}};
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_oh_s[i] = ~busy_s[i] & ~found;
            found        = found | ~busy_s[i];
            cnt_s        = cnt_s + {{(CNT_W-1){1'b0}}, ~busy_s[i]};
        end
    end

    assign free_cnt      = cnt_s;
    assign io.disp_ready = (cnt_s != {CNT_W{1'b0}});

    assign fire_s  = io.disp_valid && io.disp_ready && rdy_in && !flush;
    assign alloc_s = fire_s ? free_oh_s : {RS_DEPTH{1'b0}};
    assign load_s  = rdy_in && !flush && (!ex_valid_q || io.ex_ready) && (|ready_s);
    assign issue_s = load_s ? grant_s : {RS_DEPTH{1'b0}};

    rs_age_matrix #(
        .N (RS_DEPTH)
    ) u_age (
        .clk     (clk),
        .rst_i   (rst_in),
        .flush_i (flush && rdy_in),
        .alloc_i (alloc_s),
        .free_i  (issue_s),
        .req_i   (ready_s),
        .grant_o (grant_s)
    );

    // One-hot mux of the granted entry.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            sel_s = sel_s | ({$bits(rs_entry_t){grant_s[i]}} & src_s[i]);
        end
    end

    // Entry next-state: wakeup, issue frees, dispatch fills, flush empties.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i]      = alloc_s[i] ? new_s : ent_w[i];
            ent_d[i].busy = alloc_s[i] | (ent_q[i].busy & ~issue_s[i] & ~flush);
        end
    end

    // Issue register next-state; the slot never snoops the CDB once loaded.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_tag_d   = ex_tag_q;
        ex_v1_d    = ex_v1_q;
        ex_v2_d    = ex_v2_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (load_s) begin
            ex_valid_d = 1'b1;
            ex_op_d    = sel_s.op;
            ex_tag_d   = sel_s.tag;
            ex_v1_d    = sel_s.v1;
            ex_v2_d    = sel_s.v2;
        end else if (ex_valid_q && io.ex_ready) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // State registers; rdy_in low freezes everything, reset wins over it.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            ex_valid_q <= 1'b0;
            ex_op_q    <= {OP_W{1'b0}};
            ex_tag_q   <= {TAG_W{1'b0}};
            ex_v1_q    <= {VAL_W{1'b0}};
            ex_v2_q    <= {VAL_W{1'b0}};
        end else if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_tag_q   <= ex_tag_d;
            ex_v1_q    <= ex_v1_d;
            ex_v2_q    <= ex_v2_d;
        end
    end

    assign io.ex_valid = ex_valid_q;
    assign io.ex_op    = ex_op_q;
    assign io.ex_tag   = ex_tag_q;
    assign io.ex_v1    = ex_v1_q;
    assign io.ex_v2    = ex_v2_q;

endmodule

// File: tb/tb_rs_age_queue.sv
// Bench for rs_age_queue: directed scenarios followed by randomized traffic,
// checked against an age-ordered list model with a scoreboard of issues.
module tb_rs_age_queue;
    import rs_age_queue_pkg::*;

    localparam int D  = 8;
    localparam int P  = 3;
    localparam int CW = $clog2(D + 1);

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic [TAG_W-1:0] q1;
        logic [TAG_W-1:0] q2;
        logic [VAL_W-1:0] v1;
        logic [VAL_W-1:0] v2;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          flush;
    logic [CW-1:0] free_cnt;

    rs_age_queue_if #(.CDB_PORTS(P)) io ();

    rs_age_queue #(.RS_DEPTH(D), .CDB_PORTS(P)) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .io       (io),
        .free_cnt (free_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: waiting entries kept oldest-first.
    rec_t m_list[$];
    rec_t m_ex;
    bit   m_exv;
    bit   m_fresh;
    rec_t exp_q[$];

    // Expectations for the current cycle, consumed by the monitor.
    int   e_free;
    bit   e_exv;
    bit   e_fresh;
    rec_t e_ex;
    bit   chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Result capture rule: lowest valid port with the awaited label supplies the value.
    function automatic void wake(inout logic [TAG_W-1:0] q, inout logic [VAL_W-1:0] v);
        if (q == 0) return;
        for (int p = 0; p < P; p++) begin
            if (io.wb_valid[p] && io.wb_tag[p*TAG_W +: TAG_W] == q) begin
                v = io.wb_val[p*VAL_W +: VAL_W];
                q = 0;
                return;
            end
        end
    endfunction

    function automatic void model_step();
        rec_t r;
        logic [TAG_W-1:0] q;
        logic [VAL_W-1:0] v;
        int n0, idx;
        if (rst_in) begin
            m_list.delete();
            m_exv   = 0;
            m_fresh = 1;
            m_ex    = '{default: 0};
        end else if (rdy_in) begin
            if (flush) begin
                m_list.delete();
                m_exv = 0;
            end else begin
                n0  = m_list.size();
                idx = -1;
                if (!m_exv || io.ex_ready) begin
                    for (int k = 0; k < m_list.size(); k++) begin
                        if (m_list[k].q1 == 0 && m_list[k].q2 == 0) begin
                            idx = k;
                            break;
                        end
                    end
                end
                if (idx >= 0) begin
                    m_ex    = m_list[idx];
                    m_exv   = 1;
                    m_fresh = 0;
                    m_list.delete(idx);
                end else if (m_exv && io.ex_ready) begin
                    m_exv = 0;
                end
                for (int k = 0; k < m_list.size(); k++) begin
                    q = m_list[k].q1; v = m_list[k].v1; wake(q, v);
                    m_list[k].q1 = q; m_list[k].v1 = v;
                    q = m_list[k].q2; v = m_list[k].v2; wake(q, v);
                    m_list[k].q2 = q; m_list[k].v2 = v;
                end
                if (io.disp_valid && n0 < D) begin
                    r.op  = io.disp_op;
                    r.tag = io.disp_tag;
                    q = io.disp_q1; v = io.disp_v1; wake(q, v); r.q1 = q; r.v1 = v;
                    q = io.disp_q2; v = io.disp_v2; wake(q, v); r.q2 = q; r.v2 = v;
                    m_list.push_back(r);
                end
            end
        end
    endfunction

    // Publish expectations, predict a handshake, advance the model, step a clock.
    task automatic cycle();
        e_free  = D - m_list.size();
        e_exv   = m_exv;
        e_fresh = m_fresh;
        e_ex    = m_ex;
        if (!rst_in && rdy_in && !flush && m_exv && io.ex_ready) exp_q.push_back(m_ex);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: state compare every cycle, scoreboard pop on every DUT handshake.
    always @(negedge clk) begin
        rec_t x;
        if (chk_en) begin
            chk("free_cnt", 64'(free_cnt), 64'(e_free));
            chk("disp_ready", 64'(io.disp_ready), 64'(e_free != 0));
            chk("ex_valid", 64'(io.ex_valid), 64'(e_exv));
            if (e_exv || e_fresh) begin
                chk("ex_op", 64'(io.ex_op), 64'(e_ex.op));
                chk("ex_tag", 64'(io.ex_tag), 64'(e_ex.tag));
                chk("ex_v1", 64'(io.ex_v1), 64'(e_ex.v1));
                chk("ex_v2", 64'(io.ex_v2), 64'(e_ex.v2));
            end
            if (!rst_in && rdy_in && !flush && io.ex_valid && io.ex_ready) begin
                if (exp_q.size() == 0) begin
                    chk("issue_expected", 64'(0), 64'(1));
                end else begin
                    x = exp_q.pop_front();
                    chk("issue_tag", 64'(io.ex_tag), 64'(x.tag));
                    chk("issue_op", 64'(io.ex_op), 64'(x.op));
                    chk("issue_v1", 64'(io.ex_v1), 64'(x.v1));
                    chk("issue_v2", 64'(io.ex_v2), 64'(x.v2));
                end
            end
        end
    end

    task automatic set_idle();
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        flush         = 1'b0;
        io.disp_valid = 1'b0;
        io.disp_op    = '0;
        io.disp_tag   = '0;
        io.disp_q1    = '0;
        io.disp_q2    = '0;
        io.disp_v1    = '0;
        io.disp_v2    = '0;
        io.wb_valid   = '0;
        io.wb_tag     = '0;
        io.wb_val     = '0;
        io.ex_ready   = 1'b1;
    endtask

    task automatic set_disp(input int tag, input int q1, input int q2,
                            input logic [31:0] v1, input logic [31:0] v2);
        io.disp_valid = 1'b1;
        io.disp_op    = OP_W'(tag + 16);
        io.disp_tag   = TAG_W'(tag);
        io.disp_q1    = TAG_W'(q1);
        io.disp_q2    = TAG_W'(q2);
        io.disp_v1    = v1;
        io.disp_v2    = v2;
    endtask

    task automatic set_wb(input int port, input int tag, input logic [31:0] val);
        io.wb_valid[port]                = 1'b1;
        io.wb_tag[port*TAG_W +: TAG_W]   = TAG_W'(tag);
        io.wb_val[port*VAL_W +: VAL_W]   = val;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            set_idle();
            cycle();
        end
    endtask

    initial begin
        set_idle();
        rst_in = 1'b1;
        cycle();
        chk_en = 1'b1;
        cycle();
        idle(2);

        // Back-to-back ready dispatches.
        for (int t = 1; t <= 3; t++) begin
            set_idle();
            set_disp(t, 0, 0, 32'(t * 100), 32'(t * 7));
            cycle();
        end
        idle(3);

        // Age order: the younger ready entry overtakes the waiting one.
        set_idle(); set_disp(5, 9, 0, 32'h0, 32'h55); cycle();
        set_idle(); set_disp(6, 0, 0, 32'h66, 32'h67); cycle();
        set_idle(); set_wb(0, 9, 32'h1234); cycle();
        idle(4);

        // Dispatch racing a broadcast of its producer on port 2.
        set_idle(); set_disp(7, 0, 4, 32'h77, 32'h0); set_wb(2, 4, 32'hAA); cycle();
        idle(3);

        // Lowest port wins when two ports carry the same label.
        set_idle(); set_disp(8, 3, 0, 32'h0, 32'h1); cycle();
        set_idle(); set_wb(1, 3, 32'hB1); set_wb(2, 3, 32'hB2); cycle();
        idle(3);

        // Fill under back-pressure, hold dispatch while full, one-shot issue.
        for (int t = 1; t <= 11; t++) begin
            set_idle(); io.ex_ready = 1'b0;
            set_disp(t, 0, 0, 32'(t), 32'(t + 1));
            cycle();
        end
        set_idle(); set_disp(12, 0, 0, 32'hC, 32'hD); io.ex_ready = 1'b1; cycle();
        set_idle(); set_disp(12, 0, 0, 32'hC, 32'hD); io.ex_ready = 1'b0; cycle();
        set_idle(); io.ex_ready = 1'b0; cycle();
        idle(12);

        // Flush with a loaded issue slot and five waiting entries.
        for (int t = 1; t <= 6; t++) begin
            set_idle(); io.ex_ready = 1'b0;
            set_disp(t, 0, 0, 32'(t), 32'(t));
            cycle();
        end
        set_idle(); io.ex_ready = 1'b1; flush = 1'b1; set_disp(9, 0, 0, 32'h9, 32'h9); cycle();
        idle(2);

        // Frozen cycles: no dispatch, no handshake.
        set_idle(); set_disp(2, 0, 0, 32'h2, 32'h2); cycle();
        set_idle(); io.ex_ready = 1'b0; cycle();
        set_idle(); rdy_in = 1'b0; set_disp(3, 0, 0, 32'h3, 32'h3); cycle();
        set_idle(); rdy_in = 1'b0; flush = 1'b1; cycle();
        idle(3);

        // Randomized traffic in alternating back-pressure phases.
        for (int c = 0; c < 4000; c++) begin
            set_idle();
            rst_in      = ($urandom_range(0, 999) == 0);
            rdy_in      = ($urandom_range(0, 9) != 0);
            flush       = ($urandom_range(0, 149) == 0);
            io.ex_ready = ($urandom_range(0, 99) < (((c / 500) % 2) != 0 ? 20 : 80));
            if ($urandom_range(0, 99) < 60) begin
                set_disp(int'($urandom_range(1, 15)),
                         ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 15)),
                         ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 15)),
                         $urandom, $urandom);
            end
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(0, 1) != 0) set_wb(p, int'($urandom_range(0, 15)), $urandom);
            end
            cycle();
        end
        idle(20);
        chk("sb_drain", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rs_age_queue.md
# rs_age_queue

Parametrised reservation station for the out-of-order core. It sits between the decoder/ROB dispatch path and the ALU. It holds up to RS_DEPTH waiting instructions and snoops CDB_PORTS result broadcasts to wake dependent operands. Each cycle it hands the *oldest* ready entry to the ALU over a valid/ready handshake. Unlike the previous station, it runs on the posedge only, has N wakeup channels, does age-ordered selection, tolerates ALU back-pressure, and captures wakeups that race with dispatch.

## Interface
- RS_DEPTH, 8: entry count, ≥2.
- CDB_PORTS, 3: broadcast channels (ALU, LSB, commit).
- TAG_W, 4: ROB label width. Tag 0 means "no dependency".
- VAL_W, 32: operand width.
- OP_W, 7: opcode width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state.
- flush  in  1  mispredict flush.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry.
- disp_op  in  OP_W  opcode.
- disp_tag  in  TAG_W  destination ROB label.
- disp_q1, disp_q2  in  TAG_W  producer labels. 0 means the matching value is final.
- disp_v1, disp_v2  in  VAL_W  operand values. Immediates and PC are muxed in upstream.
- wb_valid  in  CDB_PORTS  broadcast valid, one bit per port.
- wb_tag  in  CDB_PORTS*TAG_W  packed broadcast labels; port p occupies bits [p*TAG_W +: TAG_W].
- wb_val  in  CDB_PORTS*VAL_W  packed broadcast values.
- ex_valid  out  1  issue slot holds an instruction.
- ex_ready  in  1  ALU accepts.
- ex_op  out  OP_W  issued opcode.
- ex_tag  out  TAG_W  issued ROB label.
- ex_v1, ex_v2  out  VAL_W  issued operands.
- free_cnt  out  $clog2(RS_DEPTH+1)  number of free entries.

## Operation
- Per-entry state: busy, op, tag, q1, v1, q2, v2, plus an RS_DEPTH×RS_DEPTH age matrix.
- **Dispatch.** A dispatch fires when disp_valid && disp_ready && rdy_in && !flush.
  - The entry goes into the lowest-index free slot.
  - The new entry is marked younger than every busy entry.
- **Dispatch race capture (mandatory).** If disp_qX ≠ 0 and it matches a valid wb tag in the same cycle, the entry stores the wb value with q = 0.
- **Wakeup.** For every busy entry and each operand with q ≠ 0: if the operand matches a valid wb port, set v = wb_val and q = 0.
  - Broadcasts with tag 0 are ignored.
  - If several ports match, the lowest port index wins.
- **Ready / selection.** An entry is ready when busy && q1 == 0 && q2 == 0. The selected entry is the oldest ready entry according to the age matrix.
- **Issue.** The slot loads when (!ex_valid || ex_ready) && a ready entry exists.
  - On load, the entry's fields are copied to ex_* and its busy bit is cleared in the same edge.
  - If ex_valid && ex_ready and no entry is ready, ex_valid drops to 0.
  - If ex_valid && !ex_ready, ex_* holds stable.
- **Outputs.** disp_ready = (free_cnt ≠ 0). Both are computed from the current registered state; an entry being freed this cycle does not count.
- **Flush (when rdy_in).** All busy bits, the age matrix and ex_valid clear at the next edge. Flush overrides dispatch, wakeup and issue.
- **Back-pressure on wakeup.** Operands already sitting in the issue slot are never re-woken; they were ready when loaded.

## Timing
- Reset values: ex_valid=0; ex_op, ex_tag, ex_v1, ex_v2 = 0; free_cnt=RS_DEPTH; disp_ready=1. All entries are free.
- rst_in takes priority over rdy_in. rst_in or flush in the middle of a handshake drops the pending ex instruction.
- Latency from dispatch with ready operands, accepted at edge E: ex_valid is high after edge E+1.
- Wakeup latency for a broadcast at edge W, without the configuration macro: the entry becomes selectable for the load at W+1.
- Full condition: with disp_valid held while full, nothing is written.
- Simultaneous dispatch and issue while free_cnt=0: the dispatch is refused this cycle and accepted the next cycle.
- rdy_in low: no state changes. ex_* holds; an ex_ready pulse in this cycle does not count as a handshake.

## Configuration
- RS_WAKEUP_BYPASS_EN defined: the ready computation uses post-wakeup operand state combinationally. An entry woken at edge W can be loaded into ex at edge W itself, taking its value directly from wb_val. Dispatch-then-issue latency is unchanged.
- Undefined: readiness uses registered q only, as described under Timing.

## Structure
- Shared package: TAG_NONE (0) and the entry record typedef {busy, op, tag, q1, v1, q2, v2}. OP_W, VAL_W and TAG_W defaults come from the existing util defines.
- One sub-module, rs_age_matrix:
  - Inputs: allocate one-hot, free one-hot, flush, request vector.
  - Output: oldest one-hot grant.
  - Matrix update rule: on allocate of i, set older[j][i]=1 for all busy j and clear row i.
- Free-slot search, wakeup comparators and the issue register live in rs_age_queue.

## Test plan
- **Reset.** Reset, then idle → free_cnt=8, disp_ready=1, ex_valid=0.
- **Back-to-back ready dispatch.** Dispatch three ready entries (tags 1, 2, 3) on consecutive cycles with ex_ready=1 → ex_tag sequence 1, 2, 3, each one cycle after its dispatch edge.
- **Age order.** Dispatch tag 5 (q1=9) then tag 6 (ready); then broadcast tag 9 with value 0x1234 → tag 6 issues first. Tag 5 issues later with ex_v1=0x1234.
- **Dispatch race.** Dispatch with disp_q2=4 while wb port 2 broadcasts tag 4 with value 0xAA in the same cycle → the entry issues with ex_v2=0xAA and never stalls.
- **Full and back-pressure.** Fill 8 entries with ex_ready=0 → disp_ready=0 and ex_* stable. Raise ex_ready for one cycle → exactly one entry issues and free_cnt rises by one.
- **Flush.** Assert flush with 5 busy entries and ex_valid=1 → next cycle free_cnt=8, ex_valid=0. A dispatch in the flush cycle is dropped.
